// File: rtl/control_pkg.sv
// Shared encodings for the RV32I-subset control path: opcodes, ALU op codes,
// FSM state codes and the packed control word latched in DECODE.
package control_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_PASS_B = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic       branch;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_write;
    } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder: opcode in, control word plus illegal flag out.
// Zero latency; unknown opcodes yield an all-zero control word.
module control_decode
    import control_pkg::*;
#(
    parameter int OPCODE_W = 7
)(
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_t               ctrl,
    output logic                illegal
);

    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        case (opcode)
            OPCODE_W'(OPC_LOAD): begin
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_op     = ALU_ADD;
                ctrl.alu_src    = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            OPCODE_W'(OPC_OP_IMM): begin
                ctrl.alu_op    = ALU_FUNCT;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OPCODE_W'(OPC_STORE): begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
            end
            OPCODE_W'(OPC_OP): begin
                ctrl.alu_op    = ALU_FUNCT;
                ctrl.reg_write = 1'b1;
            end
            OPCODE_W'(OPC_BRANCH): begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
            end
            OPCODE_W'(OPC_JAL): begin
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            OPCODE_W'(OPC_LUI): begin
                ctrl.alu_op    = ALU_PASS_B;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM; 3-5 cycles per instruction plus memory waits.
// Stalls in FETCH on instr_valid and in MEM on mem_ready, with an optional MEM timeout.
module multicycle_control
    import control_pkg::*;
#(
    parameter int OPCODE_W        = 7,
    parameter int ALUOP_W         = 2,
    parameter int MEM_TIMEOUT     = 16,
    parameter int TRAP_ON_ILLEGAL = 1
)(
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                instr_valid,
    input  logic                mem_ready,
    output logic                ir_write,
    output logic                pc_write,
    output logic                branch,
    output logic                jump,
    output logic                memRead,
    output logic                memWrite,
    output logic                memtoReg,
    output logic [ALUOP_W-1:0]  aluOp,
    output logic                aluSrc,
    output logic                regWrite,
    output logic                illegal,
    output logic                bus_error,
    output logic                instr_done,
    output logic [2:0]          state_out
);

    localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    state_t           state;
    ctrl_t            ctrl;
    ctrl_t            dec_ctrl;
    logic             dec_illegal;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;
    logic             in_exec;
    logic             in_mem;
    logic             in_wb;

    control_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .opcode  (opcode),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    // MEM_TIMEOUT of 0 leaves the counter saturating and never fires.
    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_FETCH;
            ctrl       <= '0;
            cnt        <= '0;
            illegal    <= 1'b0;
            bus_error  <= 1'b0;
            instr_done <= 1'b0;
        end else begin
            illegal    <= 1'b0;
            bus_error  <= 1'b0;
            instr_done <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (instr_valid) state <= S_DECODE;
                end
                S_DECODE: begin
                    ctrl <= dec_ctrl;
                    if (dec_illegal) begin
                        illegal <= 1'b1;
                        if (TRAP_ON_ILLEGAL != 0) begin
                            state <= S_HALT;
                        end else begin
                            state      <= S_FETCH;
                            instr_done <= 1'b1;
                        end
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (ctrl.mem_read || ctrl.mem_write) begin
                        state <= S_MEM;
                    end else if (ctrl.branch) begin
                        state      <= S_FETCH;
                        instr_done <= 1'b1;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        cnt <= '0;
                        if (ctrl.mem_read) begin
                            state <= S_WB;
                        end else begin
                            state      <= S_FETCH;
                            instr_done <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        cnt        <= '0;
                        bus_error  <= 1'b1;
                        instr_done <= 1'b1;
                        state      <= S_FETCH;
                    end else if (cnt != {CNT_W{1'b1}}) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WB: begin
                    state      <= S_FETCH;
                    instr_done <= 1'b1;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    assign in_exec = (state == S_EXEC);
    assign in_mem  = (state == S_MEM);
    assign in_wb   = (state == S_WB);

    // Instruction fetch handshake is the only path from an input to an output.
    assign ir_write = (state == S_FETCH) && instr_valid;
    assign pc_write = ir_write;

    assign aluOp    = (in_exec || in_mem || in_wb) ? ALUOP_W'(ctrl.alu_op) : '0;
    assign aluSrc   = (in_exec || in_mem || in_wb) && ctrl.alu_src;
    assign branch   = in_exec && ctrl.branch;
    assign jump     = in_exec && ctrl.jump;
    assign memRead  = in_mem && ctrl.mem_read;
    assign memWrite = in_mem && ctrl.mem_write;
    assign regWrite = in_wb && ctrl.reg_write;
    assign memtoReg = in_wb && ctrl.mem_to_reg;

    assign state_out = state;

endmodule
